// File: rtl/conv_mac_pipe_if.sv
// Window stream, result stream and kernel-write bundle for conv_mac_pipe.
// The engine is the slave; the window generator / pixel writer side is the master.
interface conv_mac_pipe_if #(
  parameter int TAPS   = 9,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 8,
  parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS)
);
  localparam int ADDR_W = (TAPS > 1) ? $clog2(TAPS) : 1;

  logic                     k_wr_en;
  logic [ADDR_W-1:0]        k_addr;
  logic [COEF_W-1:0]        k_data;
  logic [4:0]               shift;
  logic                     in_valid;
  logic                     in_ready;
  logic [TAPS*DATA_W-1:0]   in_win;
  logic                     out_valid;
  logic                     out_ready;
  logic [OUT_W-1:0]         out_pix;
  logic                     out_sat;
  logic [ACC_W-1:0]         out_acc;

  modport master (
    output k_wr_en, k_addr, k_data, shift, in_valid, in_win, out_ready,
    input  in_ready, out_valid, out_pix, out_sat, out_acc
  );

  modport slave (
    input  k_wr_en, k_addr, k_data, shift, in_valid, in_win, out_ready,
    output in_ready, out_valid, out_pix, out_sat, out_acc
  );
endinterface

// File: rtl/conv_mac_pipe.sv
// Three-stage multiply-accumulate engine for sliding-window convolution:
// per-tap products, adder-tree sum, then right-shift with output saturation.
module conv_mac_pipe #(
  parameter int TAPS   = 9,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 8,
  parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
  input logic            clk,
  input logic            rst,
  conv_mac_pipe_if.slave bus
);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int CMP_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W;

  logic [COEF_W-1:0] kern [TAPS];

  logic [PROD_W-1:0] s1_prod [TAPS];
  logic [4:0]        s1_shift;
  logic              s1_valid;

  logic [ACC_W-1:0]  s2_acc;
  logic [4:0]        s2_shift;
  logic              s2_valid;

  logic              out_valid_q;
  logic [OUT_W-1:0]  out_pix_q;
  logic              out_sat_q;
  logic [ACC_W-1:0]  out_acc_q;

  logic              adv;
  logic [ACC_W-1:0]  tree_sum;
  logic [CMP_W-1:0]  shifted;
  logic              sat_next;
  logic [OUT_W-1:0]  pix_next;

  // Global stall: every stage moves together whenever the output slot frees up.
  assign adv          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = adv;

  // Kernel writes ignore the stall, so coefficients can be reloaded mid-stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) kern[i] <= '0;
    end else if (bus.k_wr_en && (int'(bus.k_addr) < TAPS)) begin
      kern[bus.k_addr] <= bus.k_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_shift <= '0;
      for (int i = 0; i < TAPS; i++) s1_prod[i] <= '0;
    end else if (adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_shift <= bus.shift;
        for (int i = 0; i < TAPS; i++)
          s1_prod[i] <= PROD_W'(bus.in_win[i*DATA_W +: DATA_W]) * PROD_W'(kern[i]);
      end
    end
  end

  // ACC_W carries log2(TAPS) guard bits, so this sum can never wrap.
  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < TAPS; i++) tree_sum = tree_sum + ACC_W'(s1_prod[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_acc   <= '0;
      s2_shift <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_acc   <= tree_sum;
      s2_shift <= s1_shift;
    end
  end

  // Shifts past the accumulator width naturally produce zero and never saturate.
  always_comb begin
    shifted  = CMP_W'(s2_acc) >> s2_shift;
    sat_next = shifted > CMP_W'({OUT_W{1'b1}});
    pix_next = sat_next ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_pix_q   <= '0;
      out_sat_q   <= 1'b0;
      out_acc_q   <= '0;
    end else if (adv) begin
      out_valid_q <= s2_valid;
      out_pix_q   <= pix_next;
      out_sat_q   <= sat_next;
      out_acc_q   <= s2_acc;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_pix   = out_pix_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.out_acc   = out_acc_q;
endmodule

// File: tb/tb_conv_mac_pipe.sv
// Scoreboard bench for conv_mac_pipe: default 3x3 instance plus a 5x5 parameter-sweep instance,
// both checked against an arithmetic sum-of-products model.
module tb_conv_mac_pipe;
  localparam int T1 = 9,  D1 = 8,  C1 = 8, O1 = 8,  A1 = D1 + C1 + $clog2(T1);
  localparam int T2 = 25, D2 = 10, C2 = 6, O2 = 12, A2 = D2 + C2 + $clog2(T2);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_mac_pipe_if #(.TAPS(T1), .DATA_W(D1), .COEF_W(C1), .OUT_W(O1), .ACC_W(A1)) bus ();
  conv_mac_pipe_if #(.TAPS(T2), .DATA_W(D2), .COEF_W(C2), .OUT_W(O2), .ACC_W(A2)) bus2 ();

  conv_mac_pipe #(.TAPS(T1), .DATA_W(D1), .COEF_W(C1), .OUT_W(O1), .ACC_W(A1))
    dut (.clk(clk), .rst(rst), .bus(bus));
  conv_mac_pipe #(.TAPS(T2), .DATA_W(D2), .COEF_W(C2), .OUT_W(O2), .ACC_W(A2))
    dut2 (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct { longint acc; longint pix; bit sat; int cyc; } exp_t;

  exp_t   exp_q[$];
  exp_t   exp_q2[$];
  int     kern_m[T1];
  int     kern_m2[T2];
  longint res_acc[$], res_pix[$], res_sat[$];
  longint res2_acc[$], res2_pix[$], res2_sat[$];
  int     checks = 0;
  int     errors = 0;
  bit     lat_en = 1'b0;
  bit     stim_done;

  task automatic checkOutput(input string name, input longint got, input longint expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, expv);
    end
  endtask

  // Reference: shift the exact sum, clip to the output range.
  function automatic exp_t model(input longint sum, input int sh, input int ow, input int c);
    exp_t   e;
    longint tmp;
    longint maxv;
    tmp   = sum >> sh;
    maxv  = (longint'(1) << ow) - 1;
    e.acc = sum;
    e.sat = (tmp > maxv);
    e.pix = e.sat ? maxv : tmp;
    e.cyc = c;
    return e;
  endfunction

  function automatic logic [T1*D1-1:0] allVal(input int v);
    logic [T1*D1-1:0] r;
    for (int i = 0; i < T1; i++) r[i*D1 +: D1] = v[D1-1:0];
    return r;
  endfunction

  // Monitor for the default instance: predicts on accept, compares on transfer and while stalled.
  always @(negedge clk) begin : mon1
    exp_t   e;
    longint s;
    if (rst) begin
      exp_q.delete();
      foreach (kern_m[i]) kern_m[i] = 0;
    end else begin
      if (bus.out_valid && exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_result: got acc %0d, expected no result", bus.out_acc);
      end else if (bus.out_valid && bus.out_ready) begin
        e = exp_q.pop_front();
        checkOutput("out_acc", longint'(bus.out_acc), e.acc);
        checkOutput("out_pix", longint'(bus.out_pix), e.pix);
        checkOutput("out_sat", longint'(bus.out_sat), longint'(e.sat));
        if (lat_en) checkOutput("latency", longint'(cyc - e.cyc), 3);
        res_acc.push_back(longint'(bus.out_acc));
        res_pix.push_back(longint'(bus.out_pix));
        res_sat.push_back(longint'(bus.out_sat));
      end else if (bus.out_valid) begin
        checkOutput("held_acc", longint'(bus.out_acc), exp_q[0].acc);
        checkOutput("held_pix", longint'(bus.out_pix), exp_q[0].pix);
      end
      if (bus.in_valid && bus.in_ready) begin
        s = 0;
        for (int i = 0; i < T1; i++) s += longint'(bus.in_win[i*D1 +: D1]) * kern_m[i];
        exp_q.push_back(model(s, int'(bus.shift), O1, cyc));
      end
      if (bus.k_wr_en && int'(bus.k_addr) < T1) kern_m[bus.k_addr] = int'(bus.k_data);
    end
  end

  always @(negedge clk) begin : mon2
    exp_t   e;
    longint s;
    if (rst) begin
      exp_q2.delete();
      foreach (kern_m2[i]) kern_m2[i] = 0;
    end else begin
      if (bus2.out_valid && exp_q2.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sweep_unexpected_result: got acc %0d, expected no result", bus2.out_acc);
      end else if (bus2.out_valid && bus2.out_ready) begin
        e = exp_q2.pop_front();
        checkOutput("sweep_acc", longint'(bus2.out_acc), e.acc);
        checkOutput("sweep_pix", longint'(bus2.out_pix), e.pix);
        checkOutput("sweep_sat", longint'(bus2.out_sat), longint'(e.sat));
        res2_acc.push_back(longint'(bus2.out_acc));
        res2_pix.push_back(longint'(bus2.out_pix));
        res2_sat.push_back(longint'(bus2.out_sat));
      end
      if (bus2.in_valid && bus2.in_ready) begin
        s = 0;
        for (int i = 0; i < T2; i++) s += longint'(bus2.in_win[i*D2 +: D2]) * kern_m2[i];
        exp_q2.push_back(model(s, int'(bus2.shift), O2, cyc));
      end
      if (bus2.k_wr_en && int'(bus2.k_addr) < T2) kern_m2[bus2.k_addr] = int'(bus2.k_data);
    end
  end

  task automatic writeKern(input int addr, input int data);
    bus.k_wr_en = 1'b1;
    bus.k_addr  = addr[3:0];
    bus.k_data  = data[C1-1:0];
    @(posedge clk); #1;
    bus.k_wr_en = 1'b0;
  endtask

  task automatic writeKern2(input int addr, input int data);
    bus2.k_wr_en = 1'b1;
    bus2.k_addr  = addr[4:0];
    bus2.k_data  = data[C2-1:0];
    @(posedge clk); #1;
    bus2.k_wr_en = 1'b0;
  endtask

  task automatic applyStimulus(input logic [T1*D1-1:0] win, input logic [4:0] sh);
    bit done = 1'b0;
    bus.in_win   = win;
    bus.shift    = sh;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 500 && !done; n++) begin
      @(negedge clk);
      done = bus.in_ready;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got in_ready 0 for 500 cycles, expected 1");
    end
  endtask

  task automatic applyStimulus2(input logic [T2*D2-1:0] win, input logic [4:0] sh);
    bit done = 1'b0;
    bus2.in_win   = win;
    bus2.shift    = sh;
    bus2.in_valid = 1'b1;
    for (int n = 0; n < 500 && !done; n++) begin
      @(negedge clk);
      done = bus2.in_ready;
      @(posedge clk); #1;
    end
    bus2.in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL sweep_accept_timeout: got in_ready 0 for 500 cycles, expected 1");
    end
  endtask

  task automatic waitDrain();
    for (int n = 0; n < 500 && (exp_q.size() != 0 || exp_q2.size() != 0); n++) @(negedge clk);
    if (exp_q.size() != 0 || exp_q2.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d/%0d pending, expected 0", exp_q.size(), exp_q2.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic checkResult(input string name, input int idx, input longint acc,
                             input longint pix, input longint sat);
    if (idx >= res_acc.size()) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: got %0d results, expected at least %0d", name, res_acc.size(), idx + 1);
    end else begin
      checkOutput({name, "_acc"}, res_acc[idx], acc);
      checkOutput({name, "_pix"}, res_pix[idx], pix);
      checkOutput({name, "_sat"}, res_sat[idx], sat);
    end
  endtask

  initial begin : main
    logic [T1*D1-1:0] w;
    logic [T2*D2-1:0] w2;
    bus.k_wr_en = 0; bus.k_addr = '0; bus.k_data = '0; bus.shift = '0;
    bus.in_valid = 0; bus.in_win = '0; bus.out_ready = 1'b1;
    bus2.k_wr_en = 0; bus2.k_addr = '0; bus2.k_data = '0; bus2.shift = '0;
    bus2.in_valid = 0; bus2.in_win = '0; bus2.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_in_ready", longint'(bus.in_ready), 1);
    checkOutput("reset_out_valid", longint'(bus.out_valid), 0);
    checkOutput("reset_out_acc", longint'(bus.out_acc), 0);
    checkOutput("reset_out_pix", longint'(bus.out_pix), 0);
    checkOutput("reset_out_sat", longint'(bus.out_sat), 0);
    checkOutput("reset_sweep_valid", longint'(bus2.out_valid), 0);
    @(posedge clk); #1;

    $display("[TB] basic sum");
    for (int i = 0; i < T1; i++) writeKern(i, 1);
    for (int i = 0; i < T1; i++) w[i*D1 +: D1] = 8'(i + 1);
    res_acc.delete(); res_pix.delete(); res_sat.delete();
    lat_en = 1'b1;
    applyStimulus(w, 5'd0);
    waitDrain();
    checkResult("basic", 0, 45, 45, 0);

    $display("[TB] saturation and shift");
    for (int i = 0; i < T1; i++) writeKern(i, 255);
    res_acc.delete(); res_pix.delete(); res_sat.delete();
    applyStimulus(allVal(255), 5'd0);
    applyStimulus(allVal(255), 5'd12);
    waitDrain();
    checkResult("sat_shift0", 0, 585225, 255, 1);
    checkResult("sat_shift12", 1, 585225, 142, 0);
    lat_en = 1'b0;

    $display("[TB] backpressure");
    res_acc.delete(); res_pix.delete(); res_sat.delete();
    fork
      begin
        for (int k = 0; k < 10; k++) applyStimulus(allVal(k * 25 + 1), 5'd0);
      end
      begin
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          checkOutput("stall_in_ready", longint'(bus.in_ready), 0);
          @(posedge clk);
        end
        #1 bus.out_ready = 1'b1;
      end
    join
    waitDrain();
    checkOutput("bp_count", longint'(res_acc.size()), 10);
    for (int k = 0; k < 10 && k < res_acc.size(); k++)
      checkOutput("bp_order", res_acc[k], longint'(9 * 255 * (k * 25 + 1)));

    $display("[TB] kernel update mid-stream");
    for (int i = 0; i < T1; i++) writeKern(i, 1);
    res_acc.delete(); res_pix.delete(); res_sat.delete();
    lat_en = 1'b1;
    bus.in_win = allVal(10); bus.shift = 5'd0; bus.in_valid = 1'b1;
    bus.k_wr_en = 1'b1; bus.k_addr = 4'd4; bus.k_data = 8'd2;
    @(negedge clk);
    checkOutput("kupd_in_ready", longint'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.k_wr_en = 1'b0;
    applyStimulus(allVal(10), 5'd0);
    writeKern(9, 77);
    applyStimulus(allVal(10), 5'd0);
    waitDrain();
    checkResult("kupd_A", 0, 90, 90, 0);
    checkResult("kupd_B", 1, 100, 100, 0);
    checkResult("kaddr9_ignored", 2, 100, 100, 0);
    lat_en = 1'b0;

    $display("[TB] reset mid-operation");
    res_acc.delete(); res_pix.delete(); res_sat.delete();
    applyStimulus(allVal(1), 5'd0);
    applyStimulus(allVal(2), 5'd0);
    applyStimulus(allVal(3), 5'd0);
    rst = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("rst_out_valid", longint'(bus.out_valid), 0);
    checkOutput("rst_in_ready", longint'(bus.in_ready), 1);
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    applyStimulus(allVal(200), 5'd0);
    waitDrain();
    checkOutput("rst_count", longint'(res_acc.size()), 1);
    checkResult("post_rst", 0, 0, 0, 0);

    $display("[TB] randomized stream");
    for (int i = 0; i < T1; i++) writeKern(i, int'($urandom_range(0, 255)));
    stim_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 20000 && !stim_done; n++) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
      begin
        for (int n = 0; n < 300; n++) begin
          if ($urandom_range(0, 3) == 0) begin
            bus.k_wr_en = 1'b1;
            bus.k_addr  = 4'($urandom_range(0, 15));
            bus.k_data  = 8'($urandom_range(0, 255));
          end
          for (int i = 0; i < T1; i++) w[i*D1 +: D1] = 8'($urandom_range(0, 255));
          applyStimulus(w, ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                      : 5'($urandom_range(0, 10)));
          bus.k_wr_en = 1'b0;
          if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) begin
            @(posedge clk); #1;
          end
        end
        stim_done = 1'b1;
      end
    join
    bus.out_ready = 1'b1;
    waitDrain();

    $display("[TB] parameter sweep instance");
    for (int i = 0; i < T2; i++) writeKern2(i, 63);
    for (int i = 0; i < T2; i++) w2[i*D2 +: D2] = 10'd1023;
    applyStimulus2(w2, 5'd0);
    applyStimulus2(w2, 5'd9);
    waitDrain();
    checkOutput("sweep_count", longint'(res2_acc.size()), 2);
    if (res2_acc.size() >= 2) begin
      checkOutput("sweep_max_acc", res2_acc[0], 1611225);
      checkOutput("sweep_max_sat", res2_sat[0], 1);
      checkOutput("sweep_shift9_pix", res2_pix[1], 3146);
      checkOutput("sweep_shift9_sat", res2_sat[1], 0);
    end
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0) writeKern2(int'($urandom_range(0, 31)), int'($urandom_range(0, 63)));
      for (int i = 0; i < T2; i++) w2[i*D2 +: D2] = 10'($urandom_range(0, 1023));
      applyStimulus2(w2, 5'($urandom_range(0, 31)));
    end
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #600000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/conv_mac_pipe.md
Name: conv_mac_pipe

Overview:
Parametrised, pipelined multiply-accumulate engine for sliding-window convolution. It is the successor to the combinational 3x3 sum-of-products and is generalised in tap count and widths. It adds a runtime-loadable kernel register file, a valid/ready stream handshake, a programmable output right-shift and output saturation. It sits between the window generator (line buffers) and the output-pixel writer.

Parameters:
TAPS, 9, number of window/kernel taps (K*K); legal values 1..64.
DATA_W, 8, unsigned pixel width.
COEF_W, 8, unsigned coefficient width.
OUT_W, 8, output pixel width after shift and saturation.
ACC_W, DATA_W+COEF_W+$clog2(TAPS), accumulator width; holds the worst-case sum with no overflow.

Ports:
clk  input  1  clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
k_wr_en  input  1  kernel coefficient write strobe.
k_addr  input  $clog2(TAPS) (min 1)  coefficient index to write.
k_data  input  COEF_W  coefficient value.
shift  input  5  output right-shift amount; sampled with the window.
in_valid  input  1  window word valid.
in_ready  output  1  engine can accept a window this cycle.
in_win  input  TAPS*DATA_W  flattened window; tap i is bits [i*DATA_W +: DATA_W].
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts the result.
out_pix  output  OUT_W  shifted, saturated result.
out_sat  output  1  out_pix was clipped.
out_acc  output  ACC_W  raw unshifted sum, for debug and verification.

Behaviour:
- Reset (rst=1 at a clock edge): all kernel registers, stage valid bits, out_pix, out_sat and out_acc go to 0. out_valid=0. in_ready reads 1 in the first cycle after reset.
- Reset mid-operation: all in-flight results are discarded. The kernel returns to all-zero and must be reloaded.
- Pipeline advance: adv = !out_valid || out_ready. in_ready = adv (combinational). All stages shift only when adv=1; otherwise every stage register holds its value.
- Input acceptance: a window is accepted on a clock edge where in_valid && in_ready.
- Stage 1 (S1): registers TAPS products win[i]*kern[i], each DATA_W+COEF_W bits wide, plus shift and a valid bit. Products use the kernel value present at that clock edge.
- Stage 2 (S2): registers the unsigned adder-tree sum, zero-extended to ACC_W. This is the value later driven on out_acc.
- Stage 3 (output register): tmp = acc >> shift.
  - If tmp > 2^OUT_W-1: out_pix = all ones, out_sat = 1.
  - Otherwise: out_pix = tmp[OUT_W-1:0], out_sat = 0.
- Latency: out_valid rises 3 cycles after the accepting edge when there is no backpressure. Throughput is 1 window per cycle while out_ready=1.
- Bubbles: an S1 or S2 valid bit of 0 propagates as a bubble. Bubbles are not compressed while the pipeline is stalled (simple global stall). This is accepted behaviour.
- Output stability: while out_valid && !out_ready, out_pix, out_sat and out_acc are held stable and no results are lost or duplicated.
- Kernel write:
  - When k_wr_en=1 and k_addr<TAPS, kern[k_addr] <= k_data at the edge.
  - Writes with k_addr>=TAPS are ignored.
  - Writes are accepted regardless of adv.
- Kernel write timing:
  - A window accepted on the same edge as a write uses the old coefficient.
  - Windows accepted on later edges use the new coefficient.
  - Windows already in S1–S3 are unaffected.
- Simultaneous in_valid acceptance and out_ready=1 in the same cycle is legal; both transfers complete.
- shift >= ACC_W yields out_pix=0, out_sat=0.
- in_win is sampled only on accept. in_win and shift are don't-care when in_valid=0.

Test Plan:
- Basic sum: kernel all 1, window taps = 1..9, shift=0, out_ready=1. Required: out_acc=45, out_pix=45, out_sat=0, out_valid exactly 3 cycles after accept.
- Saturation and shift: kernel all 255, window all 255. With shift=0: out_acc=585225, out_pix=255, out_sat=1. With shift=12: out_pix=142, out_sat=0.
- Backpressure: stream 10 distinct windows back-to-back with out_ready held 0 for cycles 4–8. Required: in_ready=0 during the stall, all 10 results arrive in order with no loss or duplication, and outputs are held while stalled.
- Kernel update mid-stream: write kern[4]=2 (others 1) on the edge that accepts window A, then send window B, both all 10s. Required: A gives 90, B gives 100. A write with k_addr=9 has no effect.
- Reset mid-operation: assert rst for 1 cycle with 3 results in flight. Required: out_valid=0 the next cycle, no stale result appears afterwards, and a post-reset window with no kernel reload yields out_acc=0.
- Parameter sweep: TAPS=25, DATA_W=10, COEF_W=6, OUT_W=12. With random windows and kernels, out_acc must match the reference model. Worst case (all max inputs) must not overflow: 25*1023*63 = 1611225 fits in ACC_W=21.
